// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive-to-block path: byte FSM state
// encoding and block geometry. Optional feature macro used by the users of
// this package: RX_TIMEOUT_EN.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_HIGH
    } rx_state_e;

    localparam int BYTE_W          = 8;
    localparam int BYTES_PER_BLOCK = 16;
    localparam int BLOCK_W         = 128;

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver: 2-FF synchronizer on the serial line, bit-time counter
// and byte FSM. Emits a one-cycle byte strobe after a good stop bit and a
// one-cycle frame error pulse after a bad one. With RX_TIMEOUT_EN defined an
// extra line_idle output tells the block assembler when the line is between
// frames.
module uart_byte_rx #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] byte_data,
    output logic       byte_strobe,
    output logic       frame_err
`ifdef RX_TIMEOUT_EN
    ,
    output logic       line_idle
`endif
);
    import uart_pkg::*;

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic              rx_meta_q;
    logic              rx_sync_q;
    rx_state_e         state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        bit_idx_q;
    logic [BYTE_W-1:0] shift_q;
    logic              byte_strobe_q;
    logic              frame_err_q;

    // Two-flop synchronizer; both stages reset to the idle (high) line level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Byte FSM with bit-time counter; strobe and frame error are registered pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            byte_strobe_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            byte_strobe_q <= 1'b0;
            frame_err_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    cnt_q     <= '0;
                    bit_idx_q <= '0;
                    if (!rx_sync_q) begin
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    // Re-check the line half a bit in; a high level here was a glitch.
                    if (cnt_q == CNT_HALF) begin
                        cnt_q   <= '0;
                        state_q <= rx_sync_q ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q     <= '0;
                        shift_q   <= {rx_sync_q, shift_q[BYTE_W-1:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= ST_STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                        if (rx_sync_q) begin
                            byte_strobe_q <= 1'b1;
                            state_q       <= ST_IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= ST_WAIT_HIGH;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_WAIT_HIGH: begin
                    // A held-low (break) line must return high before a new frame.
                    if (rx_sync_q) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign byte_data   = shift_q;
    assign byte_strobe = byte_strobe_q;
    assign frame_err   = frame_err_q;
`ifdef RX_TIMEOUT_EN
    assign line_idle   = (state_q == ST_IDLE) || (state_q == ST_WAIT_HIGH);
`endif

endmodule

// File: rtl/uart_block_rx.sv
// UART receive framing block: packs 16 received bytes (first byte in the top
// byte lane) into a 128-bit block offered over valid/ready. A block that
// completes while the previous one is still unaccepted is dropped with an
// overrun pulse. Optional macro RX_TIMEOUT_EN adds an inter-byte idle timeout
// that discards a partial block; without it rx_timeout is tied low.
module uart_block_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int TIMEOUT_CLKS = 8700
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rx,
    input  logic               blk_ready,
    output logic               blk_valid,
    output logic [BLOCK_W-1:0] blk_data,
    output logic               frame_err,
    output logic               overrun,
    output logic               rx_timeout
);

    localparam int IDX_W = $clog2(BYTES_PER_BLOCK);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BYTES_PER_BLOCK - 1);

    if (CLKS_PER_BIT < 4 || TIMEOUT_CLKS < 1) begin : g_param_check
        $error("uart_block_rx: CLKS_PER_BIT must be >= 4 and TIMEOUT_CLKS >= 1");
    end

    logic [BYTE_W-1:0]  byte_data;
    logic               byte_strobe;

    logic [BLOCK_W-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [BLOCK_W-1:0] data_q, data_d;
    logic               valid_q, valid_d;
    logic               overrun_q, overrun_d;

`ifdef RX_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CLKS - 1);

    logic               line_idle;
    logic [TO_W-1:0]    idle_cnt_q, idle_cnt_d;
    logic               timeout_q, timeout_d;
`endif

    uart_byte_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_byte_rx (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx),
        .byte_data   (byte_data),
        .byte_strobe (byte_strobe),
        .frame_err   (frame_err)
`ifdef RX_TIMEOUT_EN
        ,
        .line_idle   (line_idle)
`endif
    );

    // Block assembly, output handshake and (optionally) the idle timeout.
    always_comb begin
        shift_d   = shift_q;
        idx_d     = idx_q;
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;

        if (valid_q && blk_ready) begin
            valid_d = 1'b0;
        end

        if (byte_strobe) begin
            shift_d = {shift_q[BLOCK_W-BYTE_W-1:0], byte_data};
            idx_d   = idx_q + IDX_W'(1);
            if (idx_q == IDX_LAST) begin
                // Accept the new block if the output slot is empty or being drained now.
                if (!valid_q || blk_ready) begin
                    data_d  = shift_d;
                    valid_d = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
            end
        end

`ifdef RX_TIMEOUT_EN
        idle_cnt_d = idle_cnt_q;
        timeout_d  = 1'b0;
        if (idx_q == '0 || !line_idle || byte_strobe) begin
            idle_cnt_d = '0;
        end else if (idle_cnt_q == TO_LAST) begin
            // Restarting the index is enough: a fresh block shifts out all stale bytes.
            idle_cnt_d = '0;
            idx_d      = '0;
            timeout_d  = 1'b1;
        end else begin
            idle_cnt_d = idle_cnt_q + TO_W'(1);
        end
`endif
    end

    // Block state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_q   <= '0;
            idx_q     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

`ifdef RX_TIMEOUT_EN
    // Idle timeout registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign rx_timeout = timeout_q;
`else
    assign rx_timeout = 1'b0;
`endif

    assign blk_valid = valid_q;
    assign blk_data  = data_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_block_rx.sv
// Self-checking bench for uart_block_rx: serial byte driver, scoreboard of
// expected blocks popped on every valid/ready transfer, and pulse counters.
// The timeout scenario is included only when RX_TIMEOUT_EN is defined.
module tb_uart_block_rx;

    localparam int CPB     = 47;
    localparam int TO_CLKS = 8700;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         rx = 1'b1;
    logic         blk_ready = 1'b0;
    logic         blk_valid;
    logic [127:0] blk_data;
    logic         frame_err;
    logic         overrun;
    logic         rx_timeout;

    int compared   = 0;
    int mismatched = 0;

    logic [127:0] exp_q[$];

    int fe_cnt = 0, ov_cnt = 0, to_cnt = 0, valid_cycles = 0, xfer_cnt = 0;

    uart_block_rx #(
        .CLKS_PER_BIT (CPB),
        .TIMEOUT_CLKS (TO_CLKS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .blk_ready  (blk_ready),
        .blk_valid  (blk_valid),
        .blk_data   (blk_data),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .rx_timeout (rx_timeout)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = stop_bit;
        tick(CPB);
        rx = 1'b1;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        chk({"drain_", tag}, 128'(exp_q.size()), 128'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"},   128'(blk_valid),  128'd0);
        chk({tag, "_data"},    blk_data,         128'd0);
        chk({tag, "_ferr"},    128'(frame_err),  128'd0);
        chk({tag, "_overrun"}, 128'(overrun),    128'd0);
        chk({tag, "_timeout"}, 128'(rx_timeout), 128'd0);
    endtask

    // Monitor: pulse counters, hold-stability check, scoreboard pop on transfer.
    logic         prev_hold = 1'b0;
    logic [127:0] prev_data = '0;
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            prev_hold = 1'b0;
        end else begin
            if (frame_err)  fe_cnt++;
            if (overrun)    ov_cnt++;
            if (rx_timeout) to_cnt++;
            if (blk_valid)  valid_cycles++;
            if (prev_hold) chk("hold_stable", blk_data, prev_data);
            if (blk_valid && blk_ready) begin
                xfer_cnt++;
                chk("xfer_expected", 128'(exp_q.size() != 0), 128'd1);
                if (exp_q.size() != 0) begin
                    logic [127:0] e;
                    e = exp_q.pop_front();
                    chk("blk_data", blk_data, e);
                    $display("xfer %0d: blk_data=%h expected=%h", xfer_cnt, blk_data, e);
                end
            end
            prev_hold = blk_valid && !blk_ready;
            prev_data = blk_data;
        end
    end

    initial begin
        int fe0, ov0, x0, v0, to0;
        logic [7:0]   gb[16];
        logic [127:0] e;

        // Reset state
        tick(5);
        chk_reset_outputs("rst0");
        reset = 1'b1;
        tick(5);

        // Bytes 00,11,...,FF with ready high: one-cycle valid, known block
        blk_ready = 1'b1;
        v0 = valid_cycles; x0 = xfer_cnt;
        exp_q.push_back(128'h00112233445566778899AABBCCDDEEFF);
        for (int i = 0; i < 16; i++) send_byte(8'(i * 8'h11), 1'b1);
        wait_drain("t1", 4 * CPB);
        tick(3);
        chk("t1_valid_cycles", 128'(valid_cycles - v0), 128'd1);
        chk("t1_xfers",        128'(xfer_cnt - x0),     128'd1);
        chk("t1_valid_low",    128'(blk_valid),         128'd0);

        // Frame error and false start do not advance the index
        for (int i = 0; i < 16; i++) gb[i] = 8'(8'h05 + i * 8'h13);
        e = '0;
        for (int i = 0; i < 16; i++) e = {e[119:0], gb[i]};
        fe0 = fe_cnt; x0 = xfer_cnt;
        exp_q.push_back(e);
        for (int i = 0; i < 3; i++) send_byte(gb[i], 1'b1);
        send_byte(8'hEE, 1'b0);
        tick(2 * CPB);
        chk("t2_ferr_once", 128'(fe_cnt - fe0), 128'd1);
        rx = 1'b0;
        tick(20);
        rx = 1'b1;
        tick(3 * CPB);
        chk("t3_glitch_no_ferr", 128'(fe_cnt - fe0),  128'd1);
        chk("t3_glitch_no_xfer", 128'(xfer_cnt - x0), 128'd0);
        for (int i = 3; i < 16; i++) send_byte(gb[i], 1'b1);
        wait_drain("t2", 4 * CPB);
        chk("t2_xfers",      128'(xfer_cnt - x0), 128'd1);
        chk("t2_ferr_total", 128'(fe_cnt - fe0),  128'd1);

        // Overrun: ready low, 32 bytes; first block held, second dropped
        blk_ready = 1'b0;
        ov0 = ov_cnt; x0 = xfer_cnt;
        exp_q.push_back(128'h000102030405060708090A0B0C0D0E0F);
        for (int i = 0; i < 31; i++) send_byte(8'(i), 1'b1);
        chk("t4_no_overrun_31", 128'(ov_cnt - ov0), 128'd0);
        send_byte(8'h1F, 1'b1);
        tick(5);
        chk("t4_overrun_once", 128'(ov_cnt - ov0),  128'd1);
        chk("t4_valid_held",   128'(blk_valid),     128'd1);
        chk("t4_data_held",    blk_data,            128'h000102030405060708090A0B0C0D0E0F);
        chk("t4_no_xfer",      128'(xfer_cnt - x0), 128'd0);
        blk_ready = 1'b1;
        tick(1);
        chk("t4_valid_drop",   128'(blk_valid),      128'd0);
        chk("t4_queue_empty",  128'(exp_q.size()),   128'd0);

        // Reset mid-block during byte 7, then a clean block of A5
        x0 = xfer_cnt;
        for (int i = 0; i < 6; i++) send_byte(8'(8'hC0 + i), 1'b1);
        rx = 1'b0;
        tick(CPB);
        rx = 1'b1;
        tick(CPB);
        rx = 1'b0;
        tick(CPB / 2);
        reset = 1'b0;
        tick(3);
        chk_reset_outputs("t5_rst");
        rx = 1'b1;
        tick(2);
        reset = 1'b1;
        tick(2 * CPB);
        exp_q.push_back({16{8'hA5}});
        for (int i = 0; i < 16; i++) send_byte(8'hA5, 1'b1);
        wait_drain("t5", 4 * CPB);
        chk("t5_xfers", 128'(xfer_cnt - x0), 128'd1);

`ifdef RX_TIMEOUT_EN
        // Partial block discarded after the idle limit
        to0 = to_cnt; x0 = xfer_cnt;
        for (int i = 0; i < 5; i++) send_byte(8'(8'h70 + i), 1'b1);
        tick(8000);
        chk("t6_no_timeout_early", 128'(to_cnt - to0), 128'd0);
        tick(1000);
        chk("t6_timeout_once", 128'(to_cnt - to0), 128'd1);
        exp_q.push_back(128'h000102030405060708090A0B0C0D0E0F);
        for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b1);
        wait_drain("t6", 4 * CPB);
        chk("t6_xfers",        128'(xfer_cnt - x0), 128'd1);
        chk("t6_timeout_total", 128'(to_cnt - to0), 128'd1);
`else
        to0 = to_cnt;
        chk("no_timeout_pulses", 128'(to0), 128'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
